// File: rtl/pr_block_queue_if.sv
// Handshake bundle between the prefetcher control FSM (master) and the
// prefetch data path queue (slave).
interface pr_block_queue_if #(
  parameter int ADDR_BITS      = 64,
  parameter int DATA_WIDTH     = 64,
  parameter int LOG_QUEUE_SIZE = 6
);
  logic                      pr_flush;
  logic [2:0]                pr_opCode;
  logic [ADDR_BITS-1:0]      pr_m_ar_addr;
  logic                      pr_isCleanup;
  logic [DATA_WIDTH-1:0]     m_r_data;
  logic                      pr_addrHit;
  logic                      pr_hasOutstanding;
  logic [LOG_QUEUE_SIZE:0]   pr_reqCnt;
  logic                      pr_almostFull;
  logic                      pr_r_valid;
  logic [DATA_WIDTH-1:0]     s_r_data;
  logic                      err_overflow;

  modport master (
    output pr_flush, pr_opCode, pr_m_ar_addr, pr_isCleanup, m_r_data,
    input  pr_addrHit, pr_hasOutstanding, pr_reqCnt, pr_almostFull,
           pr_r_valid, s_r_data, err_overflow
  );

  modport slave (
    input  pr_flush, pr_opCode, pr_m_ar_addr, pr_isCleanup, m_r_data,
    output pr_addrHit, pr_hasOutstanding, pr_reqCnt, pr_almostFull,
           pr_r_valid, s_r_data, err_overflow
  );
endinterface

// File: rtl/pr_block_queue.sv
// Prefetcher slice data path: circular queue of prefetched and slave-requested
// read blocks, filled in AXI order and returned to the slave from the head.
module pr_block_queue #(
  parameter int ADDR_BITS      = 64,
  parameter int DATA_WIDTH     = 64,
  parameter int LOG_QUEUE_SIZE = 6
) (
  input  logic                  clk,
  input  logic                  resetN,
  pr_block_queue_if.slave       bus
);
  localparam int DEPTH = 1 << LOG_QUEUE_SIZE;
  localparam logic [2:0] OP_PREF    = 3'd1;
  localparam logic [2:0] OP_MASTER  = 3'd2;
  localparam logic [2:0] OP_DATA    = 3'd3;
  localparam logic [2:0] OP_PROMISE = 3'd4;

  typedef logic [LOG_QUEUE_SIZE-1:0] ptr_t;
  typedef logic [LOG_QUEUE_SIZE:0]   cnt_t;

  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [DEPTH-1:0]      filled_q, filled_d;
  logic [DEPTH-1:0]      promised_q, promised_d;
  logic [ADDR_BITS-1:0]  addr_q [DEPTH];
  logic [ADDR_BITS-1:0]  addr_d [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_d [DEPTH];
  ptr_t                  head_q, head_d;
  ptr_t                  tail_q, tail_d;
  ptr_t                  fill_q, fill_d;
  cnt_t                  count_q, count_d;
  logic                  err_q, err_d;

  logic                  hit;
  ptr_t                  hit_idx;
  ptr_t                  scan_idx;
  logic [DEPTH-1:0]      head_oh;
  logic                  full;
  logic                  any_unfilled;
  logic                  younger_promised;
  logic                  outstanding;
  logic                  head_ready;
  logic                  is_alloc_op;
  logic                  do_alloc;
  logic                  overflow;
  logic                  do_fill;
  logic                  do_mark;
  logic                  do_pop;
  logic                  do_drop;
  logic                  head_adv;

  // Oldest unpromised entry whose address matches; scan starts at the head.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = head_q;
    scan_idx = head_q;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = head_q + ptr_t'(k);
      if (!hit && valid_q[scan_idx] && !promised_q[scan_idx] &&
          (addr_q[scan_idx] == bus.pr_m_ar_addr)) begin
        hit     = 1'b1;
        hit_idx = scan_idx;
      end
    end
  end

  always_comb begin
    head_oh         = '0;
    head_oh[head_q] = 1'b1;
  end

  assign full             = (count_q == cnt_t'(DEPTH));
  assign any_unfilled     = |(valid_q & ~filled_q);
  assign younger_promised = |(valid_q & promised_q & ~head_oh);
  assign outstanding      = (fill_q != tail_q) || (full && any_unfilled);
  assign head_ready       = valid_q[head_q] & filled_q[head_q] & promised_q[head_q];

  // Per-cycle opcode decode against registered state.
  always_comb begin
    is_alloc_op = (bus.pr_opCode == OP_PREF) ||
                  ((bus.pr_opCode == OP_MASTER) && !hit);
    do_alloc    = is_alloc_op && !full;
    overflow    = is_alloc_op && full;
    do_mark     = (bus.pr_opCode == OP_MASTER) && hit;
    do_fill     = (bus.pr_opCode == OP_DATA) && outstanding;
    do_pop      = (bus.pr_opCode == OP_PROMISE) && head_ready;
    // A head that is being promised this cycle must not be dropped under it.
    do_drop     = !do_pop && valid_q[head_q] && filled_q[head_q] &&
                  !promised_q[head_q] &&
                  (younger_promised || bus.pr_isCleanup) &&
                  !(do_mark && (hit_idx == head_q));
    head_adv    = do_pop || do_drop;
  end

  always_comb begin
    valid_d    = valid_q;
    filled_d   = filled_q;
    promised_d = promised_q;
    addr_d     = addr_q;
    data_d     = data_q;
    head_d     = head_q;
    tail_d     = tail_q;
    fill_d     = fill_q;
    count_d    = count_q;
    err_d      = err_q | overflow;
    if (bus.pr_flush) begin
      valid_d    = '0;
      filled_d   = '0;
      promised_d = '0;
      head_d     = '0;
      tail_d     = '0;
      fill_d     = '0;
      count_d    = '0;
      err_d      = 1'b0;
    end else begin
      if (do_mark) begin
        promised_d[hit_idx] = 1'b1;
      end
      if (do_fill) begin
        filled_d[fill_q] = 1'b1;
        data_d[fill_q]   = bus.m_r_data;
        fill_d           = fill_q + ptr_t'(1);
      end
      if (head_adv) begin
        valid_d[head_q]    = 1'b0;
        filled_d[head_q]   = 1'b0;
        promised_d[head_q] = 1'b0;
        head_d             = head_q + ptr_t'(1);
      end
      if (do_alloc) begin
        valid_d[tail_q]    = 1'b1;
        filled_d[tail_q]   = 1'b0;
        promised_d[tail_q] = (bus.pr_opCode == OP_MASTER);
        addr_d[tail_q]     = bus.pr_m_ar_addr;
        tail_d             = tail_q + ptr_t'(1);
      end
      count_d = count_q + cnt_t'(do_alloc) - cnt_t'(head_adv);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      valid_q    <= '0;
      filled_q   <= '0;
      promised_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      fill_q     <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      filled_q   <= filled_d;
      promised_q <= promised_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      fill_q     <= fill_d;
      count_q    <= count_d;
      err_q      <= err_d;
    end
  end

  // Payload storage carries no reset; it is only observed through valid flags.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  assign bus.pr_addrHit        = (bus.pr_opCode == OP_MASTER) && hit;
  assign bus.pr_hasOutstanding = outstanding;
  assign bus.pr_reqCnt         = count_q;
  assign bus.pr_almostFull     = (count_q >= cnt_t'(DEPTH - 1));
  assign bus.pr_r_valid        = head_ready;
  assign bus.s_r_data          = valid_q[head_q] ? data_q[head_q] : '0;
  assign bus.err_overflow      = err_q;
endmodule

// File: doc/pr_block_queue.md
Name: pr_block_queue

Overview:
- Prefetch data path for one prefetcher slice; executes the per-cycle opcode issued by the prefetcher control FSM.
- Holds a circular queue of outstanding and completed read transactions: prefetched blocks plus slave-requested blocks.
- Matches slave read addresses against prefetched entries and fills entries with DDR read data in AXI order.
- Returns the head entry's data to the slave (NVDLA) and reports occupancy and status flags back to the control FSM.

Parameters:
ADDR_BITS, 64, address width
DATA_WIDTH, 64, width of one read data entry
LOG_QUEUE_SIZE, 6, queue depth is 2^LOG_QUEUE_SIZE entries

Ports:
clk  in  1  clock
resetN  in  1  reset
pr_flush  in  1  synchronous clear of all entries
pr_opCode  in  3  0 NOP, 1 readReqPref, 2 readReqMaster, 3 readDataSlave, 4 readDataPromise
pr_m_ar_addr  in  ADDR_BITS  address for opcodes 1/2
pr_isCleanup  in  1  control FSM in cleanup
m_r_data  in  DATA_WIDTH  DDR read data, captured on opcode 3
pr_addrHit  out  1  combinational hit for the current opcode 2
pr_hasOutstanding  out  1  some entry is awaiting DDR data
pr_reqCnt  out  LOG_QUEUE_SIZE+1  occupied entries
pr_almostFull  out  1  pr_reqCnt >= 2^LOG_QUEUE_SIZE-1
pr_r_valid  out  1  head entry is filled and promised
s_r_data  out  DATA_WIDTH  head entry data
err_overflow  out  1  sticky: allocation attempted while full

Behaviour:
- Reset resetN: asynchronous, active-low; clock clk.
- Reset values:
  - All entry flags (valid, filled, promised) = 0.
  - head, tail and fill pointers = 0; count = 0.
  - err_overflow = 0.
  - Consequently every derived output is 0 and s_r_data = 0.
- Entry fields: addr, data, filled, promised.
- Queue order: head = oldest entry; fill pointer = oldest unfilled entry; tail = next free slot.
- Pointer width is LOG_QUEUE_SIZE; pointers wrap modulo depth.
- Count is tracked separately, so full (count = depth) and empty (count = 0) are unambiguous when head equals tail.
- pr_flush (sync): clears all entries, pointers, count and err_overflow next edge. It has priority over every opcode that cycle.
- Opcode 1 (readReqPref): allocate at tail with addr = pr_m_ar_addr, filled = 0, promised = 0.
- Opcode 2 (readReqMaster):
  - pr_addrHit = 1 in the same cycle iff some valid entry has addr == pr_m_ar_addr and promised = 0.
  - On hit: the oldest matching entry gets promised = 1 at the edge.
  - On miss: allocate at tail with promised = 1, filled = 0.
- Opcode 3 (readDataSlave):
  - Writes m_r_data into the entry at the fill pointer, sets filled = 1, and advances the fill pointer.
  - If no unfilled entry exists, the opcode is ignored.
- Opcode 4 (readDataPromise): pops the head; valid only when pr_r_valid = 1, otherwise ignored.
- Drop rule, evaluated each cycle when no opcode-4 pop occurs: the head is popped if it is filled, promised = 0, and either:
  - some younger entry is promised, or
  - pr_isCleanup = 1.
- At most one head advance per cycle.
- Head advance and tail allocation in the same cycle: count stays unchanged.
- Allocation while count = depth: no write, err_overflow set, all other state unchanged.
- pr_hasOutstanding = (fill pointer != tail) or (count = depth and some entry is unfilled).
- Outputs pr_r_valid, s_r_data, pr_reqCnt, pr_almostFull and pr_hasOutstanding derive combinationally from registered state, with zero added latency.
- Entry data is observable on s_r_data the cycle after opcode 3.
- Address compare: full ADDR_BITS equality, unsigned; no partial or range matching.

Test Plan:
1. Flow with no match: reset; opcode 1 at addrs 0x1000 then 0x1040 -> pr_reqCnt = 2, pr_hasOutstanding = 1. Two opcode 3 with data 0xA, 0xB -> pr_hasOutstanding = 0, pr_r_valid = 0 (no promise).
2. Hit and return: from scenario 1, opcode 2 addr 0x1000 -> pr_addrHit = 1 same cycle; next cycle pr_r_valid = 1, s_r_data = 0xA. Opcode 4 -> pr_reqCnt = 1.
3. Miss and drop: opcode 1 at 0x2000, filled; then opcode 2 at 0x3000 -> pr_addrHit = 0, new promised entry allocated, pr_reqCnt = 2. Next cycle the head (0x2000) is dropped -> pr_reqCnt = 1. Opcode 3 with 0xC -> pr_r_valid = 1, s_r_data = 0xC.
4. Full and wrap: fill 64 entries -> pr_almostFull = 1 at 63. Allocate a 65th -> err_overflow = 1, pr_reqCnt stays 64. Pop/drop all, then allocate 70 more in batches -> pointers wrap and data ordering stays correct.
5. Cleanup and flush: three filled, unpromised entries with pr_isCleanup = 1 -> one drop per cycle, pr_reqCnt = 0 after 3 cycles. pr_flush together with opcode 1 -> pr_reqCnt = 0, no allocation.
6. Reset mid-operation: assert resetN = 0 with 5 entries, 2 of them outstanding -> all outputs 0 immediately (asynchronous); after release, opcode 3 is ignored.
